// File: rtl/prog_readback_pkg.sv
// Shared program-loader package.
// Holds the readback FSM state encoding, the default program-memory
// geometry and the fixed LED patterns. Both the loader write side and
// the readback side import this so they agree on widths and encodings.
package prog_readback_pkg;

  localparam int RB_ADDR_W = 8;
  localparam int RB_DATA_W = 16;   // always two LED bytes per word

  localparam logic [7:0] IDLE_PATTERN = 8'h00;
  localparam logic [7:0] DONE_PATTERN = 8'hFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT    = 3'd2,
    SHOW_LO = 3'd3,
    SHOW_HI = 3'd4,
    DONE    = 3'd5
  } rbState_t;

  // Pick one LED byte out of a program word.
  function automatic logic [7:0] byteSel(input logic [15:0] w, input logic hi);
    return hi ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/prog_readback_if.sv
// Operator/memory bus for the program readback block.
//   start, enter : debounced single-cycle button pulses
//   switch       : start address from the DIP switches
//   addrRd       : program-memory read address
//   dataRd       : program-memory read data, one cycle after addrRd
//   outPattern   : LED byte
//   busy         : dump in progress
//   showHigh     : high byte of the current word is on the LEDs
// master = buttons/memory side, slave = readback block.
interface prog_readback_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              start;
  logic              enter;
  logic [7:0]        switch;
  logic [ADDR_W-1:0] addrRd;
  logic [DATA_W-1:0] dataRd;
  logic [7:0]        outPattern;
  logic              busy;
  logic              showHigh;

  modport master (
    output start, enter, switch, dataRd,
    input  addrRd, outPattern, busy, showHigh
  );

  modport slave (
    input  start, enter, switch, dataRd,
    output addrRd, outPattern, busy, showHigh
  );
endinterface

// File: rtl/prog_readback.sv
// Program-memory readback: dumps words from a start address up to
// LAST_ADDR onto an 8-bit LED bank, low byte then high byte, stepping
// on each enter pulse.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - prog_readback_if.slave (buttons, switches, memory port, LEDs)
// Build option: READBACK_CHECKSUM_EN adds a mod-256 sum of every byte
// shown, displayed in DONE in place of the fixed 8'hFF.
module prog_readback
  import prog_readback_pkg::*;
#(
  parameter int                ADDR_W    = RB_ADDR_W,
  parameter int                DATA_W    = RB_DATA_W,
  parameter logic [ADDR_W-1:0] LAST_ADDR = '1
) (
  input  logic            clk,
  input  logic            rst,
  prog_readback_if.slave  bus
);

  rbState_t          state, stateNext;
  logic [ADDR_W-1:0] addrQ, addrNext;
  logic [DATA_W-1:0] word, wordNext;
  logic [7:0]        outQ, outNext;
`ifdef READBACK_CHECKSUM_EN
  logic [7:0]        sumQ, sumNext;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addrQ <= '0;
      word  <= '0;
      outQ  <= IDLE_PATTERN;
`ifdef READBACK_CHECKSUM_EN
      sumQ  <= '0;
`endif
    end else begin
      addrQ <= addrNext;
      word  <= wordNext;
      outQ  <= outNext;
`ifdef READBACK_CHECKSUM_EN
      sumQ  <= sumNext;
`endif
    end
  end

  always_comb begin
    stateNext = state;
    addrNext  = addrQ;
    wordNext  = word;
    outNext   = outQ;
    // start wins over enter in every state; enter outside SHOW_* is dropped
    if (bus.start) begin
      stateNext = FETCH;
      addrNext  = ADDR_W'(bus.switch);
    end else begin
      case (state)
        FETCH:   stateNext = WAIT;
        WAIT: begin
          wordNext  = bus.dataRd;
          stateNext = SHOW_LO;
        end
        SHOW_LO: if (bus.enter) stateNext = SHOW_HI;
        SHOW_HI: if (bus.enter) begin
          if (addrQ != LAST_ADDR) begin
            addrNext  = addrQ + ADDR_W'(1);
            stateNext = FETCH;
          end else begin
            stateNext = DONE;   // hold addrQ at LAST_ADDR, no wrap
          end
        end
        default: ;
      endcase
    end

    // LED register is loaded from next-state so the first byte appears
    // the same edge the word is captured (3 cycles after start).
    // FETCH/WAIT keep whatever was last shown.
    case (stateNext)
      IDLE:    outNext = IDLE_PATTERN;
      SHOW_LO: outNext = byteSel(wordNext, 1'b0);
      SHOW_HI: outNext = byteSel(wordNext, 1'b1);
`ifdef READBACK_CHECKSUM_EN
      DONE:    outNext = sumNext;
`else
      DONE:    outNext = DONE_PATTERN;
`endif
      default: ;
    endcase
  end

`ifdef READBACK_CHECKSUM_EN
  // Each byte is added once, on the edge that first puts it on the LEDs.
  always_comb begin
    sumNext = sumQ;
    if (bus.start)                          sumNext = '0;
    else if (state == WAIT)                 sumNext = sumQ + bus.dataRd[7:0];
    else if (state == SHOW_LO && bus.enter) sumNext = sumQ + word[15:8];
  end
`endif

  assign bus.addrRd     = addrQ;
  assign bus.outPattern = outQ;
  assign bus.busy       = (state != IDLE) && (state != DONE);
  assign bus.showHigh   = (state == SHOW_HI);

endmodule

// File: tb/tb_prog_readback.sv
module tb_prog_readback;

  logic clk;
  logic rst;
  logic [15:0] mem [256];
  int nChecks = 0;
  int nFail   = 0;

  prog_readback_if #(.ADDR_W(8), .DATA_W(16)) b();

  prog_readback dut (.clk(clk), .rst(rst), .bus(b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: data for an address arrives one cycle later.
  always @(posedge clk) b.dataRd <= mem[b.addrRd];

  typedef struct {
    logic [7:0] sw;
    int         n;
    logic [7:0] out;
    logic       sh;
    logic       busy;
    logic [7:0] addr;
  } vec_t;

  vec_t tbl[11];

`ifdef READBACK_CHECKSUM_EN
  localparam logic [7:0] DONE_FE = 8'h0A;
  localparam logic [7:0] DONE_FF = 8'h07;
  localparam bit CSUM = 1'b1;
`else
  localparam logic [7:0] DONE_FE = 8'hFF;
  localparam logic [7:0] DONE_FF = 8'hFF;
  localparam bit CSUM = 1'b0;
`endif

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart(input logic [7:0] sw);
    b.switch = sw;
    b.start  = 1'b1;
    tick();
    b.start  = 1'b0;
  endtask

  task automatic pulseEnter();
    b.enter = 1'b1;
    tick();
    b.enter = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp[$];
    logic [7:0] s;
    logic [7:0] sum;
    logic [7:0] donePat;

    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[2]    = 16'h7788;
    mem[5]    = 16'hA55A;
    mem[6]    = 16'h1234;
    mem[7]    = 16'hBEEF;
    mem[8'hFE] = 16'h0102;
    mem[8'hFF] = 16'h0304;

    tbl[0]  = '{8'h05, 0, 8'h5A, 1'b0, 1'b1, 8'h05};
    tbl[1]  = '{8'h05, 1, 8'hA5, 1'b1, 1'b1, 8'h05};
    tbl[2]  = '{8'h05, 2, 8'h34, 1'b0, 1'b1, 8'h06};
    tbl[3]  = '{8'h05, 3, 8'h12, 1'b1, 1'b1, 8'h06};
    tbl[4]  = '{8'hFE, 0, 8'h02, 1'b0, 1'b1, 8'hFE};
    tbl[5]  = '{8'hFE, 1, 8'h01, 1'b1, 1'b1, 8'hFE};
    tbl[6]  = '{8'hFE, 2, 8'h04, 1'b0, 1'b1, 8'hFF};
    tbl[7]  = '{8'hFE, 3, 8'h03, 1'b1, 1'b1, 8'hFF};
    tbl[8]  = '{8'hFE, 4, DONE_FE, 1'b0, 1'b0, 8'hFF};
    tbl[9]  = '{8'hFF, 2, DONE_FF, 1'b0, 1'b0, 8'hFF};
    tbl[10] = '{8'hFF, 5, DONE_FF, 1'b0, 1'b0, 8'hFF};

    b.start = 1'b0; b.enter = 1'b0; b.switch = 8'h00;
    rst = 1'b0;
    #1;
    chk("rst_out",  16'(b.outPattern), 16'h00);
    chk("rst_busy", 16'(b.busy), 16'h0);
    chk("rst_sh",   16'(b.showHigh), 16'h0);
    chk("rst_addr", 16'(b.addrRd), 16'h00);
    #22 rst = 1'b1;
    tick();

    // Exact start latency: nothing at cycle 2, first byte at cycle 3.
    pulseStart(8'h05);
    chk("lat_busy", 16'(b.busy), 16'h1);
    tick();
    chk("lat_c2_out", 16'(b.outPattern), 16'h00);
    tick();
    chk("lat_c3_out", 16'(b.outPattern), 16'h5A);
    chk("lat_c3_sh",  16'(b.showHigh), 16'h0);
    pulseEnter();
    chk("lat_hi_out", 16'(b.outPattern), 16'hA5);
    chk("lat_hi_sh",  16'(b.showHigh), 16'h1);

    // start with simultaneous enter in SHOW_HI at address 7.
    pulseStart(8'h07);
    tick(); tick();
    pulseEnter();
    chk("pri_pre_out", 16'(b.outPattern), 16'hBE);
    b.switch = 8'h02; b.start = 1'b1; b.enter = 1'b1;
    tick();
    b.start = 1'b0; b.enter = 1'b0;
    chk("pri_addr", 16'(b.addrRd), 16'h02);
    chk("pri_sh",   16'(b.showHigh), 16'h0);
    chk("pri_busy", 16'(b.busy), 16'h1);
    tick(); tick();
    chk("pri_lo", 16'(b.outPattern), 16'h88);
    pulseEnter();
    chk("pri_hi", 16'(b.outPattern), 16'h77);

    // Reset in WAIT, then enters in IDLE, then a fresh start.
    pulseStart(8'h05);
    tick();
    #2 rst = 1'b0;
    #1;
    chk("wrst_out",  16'(b.outPattern), 16'h00);
    chk("wrst_busy", 16'(b.busy), 16'h0);
    chk("wrst_addr", 16'(b.addrRd), 16'h00);
    chk("wrst_sh",   16'(b.showHigh), 16'h0);
    #3 rst = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      pulseEnter();
      tick();
    end
    chk("idle_out",  16'(b.outPattern), 16'h00);
    chk("idle_busy", 16'(b.busy), 16'h0);
    pulseStart(8'h05);
    tick(); tick();
    chk("post_rst_out", 16'(b.outPattern), 16'h5A);

    // Table of start address / enter count vectors.
    for (int i = 0; i < 11; i++) begin
      pulseStart(tbl[i].sw);
      tick(); tick();
      for (int k = 0; k < tbl[i].n; k++) begin
        pulseEnter();
        tick(); tick(); tick();
      end
      chk($sformatf("tbl%0d_out", i),  16'(b.outPattern), 16'(tbl[i].out));
      chk($sformatf("tbl%0d_sh", i),   16'(b.showHigh), 16'(tbl[i].sh));
      chk($sformatf("tbl%0d_busy", i), 16'(b.busy), 16'(tbl[i].busy));
      chk($sformatf("tbl%0d_addr", i), 16'(b.addrRd), 16'(tbl[i].addr));
    end

    // Random dumps near the end of memory against a byte-list model.
    for (int it = 0; it < 20; it++) begin
      for (int a = 8'hF8; a <= 8'hFF; a++) mem[a] = 16'($urandom);
      s = 8'hF8 + 8'($urandom_range(0, 7));
      exp.delete();
      sum = 8'h00;
      for (int a = s; a <= 8'hFF; a++) begin
        exp.push_back(mem[a][7:0]);
        exp.push_back(mem[a][15:8]);
        sum = sum + mem[a][7:0] + mem[a][15:8];
      end
      donePat = CSUM ? sum : 8'hFF;

      pulseStart(s);
      tick(); tick();
      chk($sformatf("rnd%0d_b0", it), 16'(b.outPattern), 16'(exp[0]));
      for (int p = 1; p < exp.size(); p++) begin
        repeat ($urandom_range(0, 2)) tick();
        pulseEnter();
        if (p % 2 == 0) begin
          // enter during FETCH must be dropped
          if ($urandom_range(0, 1) == 1) pulseEnter();
          else tick();
          tick();
        end
        chk($sformatf("rnd%0d_b%0d", it, p), 16'(b.outPattern), 16'(exp[p]));
        chk($sformatf("rnd%0d_sh%0d", it, p), 16'(b.showHigh), 16'(p % 2));
      end
      pulseEnter();
      chk($sformatf("rnd%0d_done", it), 16'(b.outPattern), 16'(donePat));
      chk($sformatf("rnd%0d_busy", it), 16'(b.busy), 16'h0);
      chk($sformatf("rnd%0d_addr", it), 16'(b.addrRd), 16'hFF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/prog_readback.md
PROG_READBACK -- requirements
Module: prog_readback

Interface
REQ-001 Parameter ADDR_W, default 8, program-memory address width.
REQ-002 Parameter DATA_W, default 16, program-memory word width; fixed at 2*8.
REQ-003 Parameter LAST_ADDR, default 8'hFF, final address dumped before DONE.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 start  input  1  debounced single-cycle pulse; begins dump at address switch.
REQ-008 enter  input  1  debounced single-cycle pulse; advances to next byte.
REQ-009 switch  input  8  start address, sampled only on start.
REQ-010 addrRd  output  ADDR_W  read address to memory read port.
REQ-011 dataRd  input  DATA_W  memory read data, valid one cycle after addrRd changes.
REQ-012 outPattern  output  8  byte shown on LEDs.
REQ-013 busy  output  1  high in any state other than IDLE and DONE.
REQ-014 showHigh  output  1  high while high byte of current word is displayed.

Function
REQ-015 FSM states SHALL be IDLE, FETCH, WAIT, SHOW_LO, SHOW_HI, DONE.
REQ-016 IDLE: outPattern 8'h00; start -> load addrRd=switch, go FETCH.
REQ-017 FETCH: addrRd stable, go WAIT next cycle (one-cycle read latency).
REQ-018 WAIT: capture dataRd into internal 16-bit word register, go SHOW_LO.
REQ-019 SHOW_LO: outPattern=word[7:0], showHigh=0; enter -> SHOW_HI.
REQ-020 SHOW_HI: outPattern=word[15:8], showHigh=1; enter with addrRd!=LAST_ADDR -> addrRd+1, FETCH.
REQ-021 SHOW_HI with addrRd==LAST_ADDR and enter -> DONE; addrRd SHALL NOT wrap.
REQ-022 DONE: outPattern=8'hFF (see REQ-030), busy=0; start -> restart as REQ-016.
REQ-023 start in any state SHALL take priority over enter and restart from switch address.
REQ-024 enter in IDLE, FETCH, WAIT or DONE SHALL be ignored, not queued.
REQ-025 Latency start -> first byte on outPattern SHALL be exactly 3 clock cycles.
REQ-026 outPattern SHALL be registered (no combinational path from dataRd).

Reset
REQ-027 rst low SHALL force IDLE, addrRd=0, word=0, outPattern=8'h00, busy=0, showHigh=0 immediately, including mid-dump.
REQ-028 After rst release, first start SHALL behave as from power-up.

Configuration
REQ-029 Macro READBACK_CHECKSUM_EN SHALL compile in an 8-bit modulo-256 sum of every byte shown in SHOW_LO/SHOW_HI (each byte counted once on entry), cleared on start and reset.
REQ-030 With READBACK_CHECKSUM_EN, DONE shows the checksum; without it, DONE shows 8'hFF and no checksum logic exists.

Structure
REQ-031 State encoding, ADDR_W/DATA_W defaults and the DONE pattern 8'hFF SHALL live in the shared program-loader package used by the write-side logic.
REQ-032 Single flat module; no sub-module.

Verification
REQ-033 Mem[5]=16'hA55A, switch=5, start -> after 3 cycles outPattern=8'h5A, showHigh=0; enter -> 8'hA5, showHigh=1.
REQ-034 switch=8'hFE, mem[FE]=16'h0102, mem[FF]=16'h0304, four enters -> 02,01,04,03 then DONE with 8'hFF, addrRd stays 8'hFF.
REQ-035 With READBACK_CHECKSUM_EN, REQ-034 sequence -> DONE shows 8'h0A.
REQ-036 start asserted in SHOW_HI at address 7 with switch=2 -> FETCH at addrRd=2, same cycle enter ignored.
REQ-037 rst low during WAIT -> outputs reset immediately; enter pulses in IDLE leave outPattern=8'h00.
